lif_neuron: RTL

LIF_NEURON -- requirements
Module: lif_neuron

---
 rtl/lif_neuron.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: accumulates weighted presynaptic spikes one input
// per cycle, applies leak, fires and enters a refractory period when over threshold.
module lif_neuron #(
    parameter int WEIGHT_SIZE   = 16,
    parameter int N_INPUTS      = 4,
    parameter int POT_SIZE      = 20,
    parameter int THRESHOLD     = 100,
    parameter int LEAK_SHIFT    = 3,
    parameter int REFRACT_STEPS = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            step,
    input  logic [N_INPUTS-1:0]             spk_in,
    input  logic [N_INPUTS*WEIGHT_SIZE-1:0] weights,
    output logic                            spk_post,
    output logic [7:0]                      time_step,
    output logic                            done,
    output logic                            busy,
    output logic [POT_SIZE-1:0]             potential
);

    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int REF_W = (REFRACT_STEPS > 0) ? $clog2(REFRACT_STEPS + 1) : 1;
    localparam int SUM_W = ((POT_SIZE > WEIGHT_SIZE) ? POT_SIZE : WEIGHT_SIZE) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CMP   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [POT_SIZE-1:0]  pot_q, pot_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [REF_W-1:0]     refr_q, refr_d;
    logic [N_INPUTS-1:0]  lat_q, lat_d;
    logic [7:0]           ts_q, ts_d;
    logic                 spk_q, spk_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic [WEIGHT_SIZE-1:0] weight_s;
    logic [SUM_W-1:0]       sum_s;
    logic [POT_SIZE-1:0]    sat_s;
    logic [POT_SIZE-1:0]    leak_s;

    // Datapath: selected weight, saturating add and leaked potential
    always_comb begin
        weight_s = weights[idx_q*WEIGHT_SIZE +: WEIGHT_SIZE];
        sum_s    = SUM_W'(pot_q) + SUM_W'(weight_s);
        if (|sum_s[SUM_W-1:POT_SIZE]) begin
            sat_s = {POT_SIZE{1'b1}};
        end else begin
            sat_s = sum_s[POT_SIZE-1:0];
        end
        leak_s = pot_q - (pot_q >> LEAK_SHIFT);
    end

    // Next-state and output decode
    always_comb begin
        state_d = state_q;
        pot_d   = pot_q;
        idx_d   = idx_q;
        refr_d  = refr_q;
        lat_d   = lat_q;
        ts_d    = ts_q;
        spk_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (step) begin
                    if (refr_q == {REF_W{1'b0}}) begin
                        lat_d   = spk_in;
                        idx_d   = {IDX_W{1'b0}};
                        state_d = ACCUM;
                    end else begin
                        // Refractory step: time advances but no integration happens
                        refr_d = refr_q - REF_W'(1);
                        done_d = 1'b1;
                        ts_d   = ts_q + 8'd1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (lat_q[idx_q]) begin
                    pot_d = sat_s;
                end else begin
                    pot_d = pot_q;
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = CMP;
                end else begin
                    state_d = ACCUM;
                end
            end
            CMP: begin
                done_d  = 1'b1;
                ts_d    = ts_q + 8'd1;
                state_d = IDLE;
                if (leak_s >= POT_SIZE'(THRESHOLD)) begin
                    spk_d  = 1'b1;
                    pot_d  = {POT_SIZE{1'b0}};
                    refr_d = REF_W'(REFRACT_STEPS);
                end else begin
                    pot_d = leak_s;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pot_q   <= {POT_SIZE{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            refr_q  <= {REF_W{1'b0}};
            lat_q   <= {N_INPUTS{1'b0}};
            ts_q    <= 8'd0;
            spk_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pot_q   <= pot_d;
            idx_q   <= idx_d;
            refr_q  <= refr_d;
            lat_q   <= lat_d;
            ts_q    <= ts_d;
            spk_q   <= spk_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign spk_post  = spk_q;
    assign time_step = ts_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign potential = pot_q;

endmodule
